// File: rtl/mips_main_controller_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcode values,
// ALU class codes, datapath select encodings and the controller state set.
package mips_pkg;

    // Instruction opcodes (instr[31:26]) understood by the controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU class codes handed to the ALU function decoder (2'b11 is unused)
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Controller states, one per step of the multicycle sequence
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } ctrl_state_t;

    // Every datapath control the FSM produces, bundled for the decoder
    typedef struct packed {
        logic       ior_d;
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_operation;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
    } ctrl_outputs_t;

    // States that sit on the memory and wait for mem_ready
    function automatic logic is_wait_state(ctrl_state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

    // Opcodes the decode step knows how to dispatch
    function automatic logic is_legal_opcode(logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_ctrl_output_decode.sv
// Combinational map from controller state to every datapath control.
// Moore outputs, except the FETCH loads which also wait on mem_ready.
module mips_ctrl_output_decode
    import mips_pkg::*;
(
    input  ctrl_state_t   state,
    input  logic          mem_ready,
    input  logic          reset,
    input  logic [5:0]    opcode,
    output ctrl_outputs_t ctrl
);

    // All controls default to zero; reset forces them to stay there so no
    // write enable can fire while an instruction is being aborted.
    always_comb begin
        ctrl = '0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_req       = 1'b1;
                    ctrl.ior_d         = 1'b0;
                    ctrl.alu_src_a     = 1'b0;
                    ctrl.alu_src_b     = SRCB_FOUR;
                    ctrl.alu_operation = ALUOP_ADD;
                    ctrl.pc_src        = PCSRC_ALURESULT;
                    ctrl.ir_write      = mem_ready;
                    ctrl.pc_write      = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_a     = 1'b0;
                    ctrl.alu_src_b     = SRCB_IMM_SH2;
                    ctrl.alu_operation = ALUOP_ADD;
                    ctrl.illegal_op    = !is_legal_opcode(opcode);
                end
                S_MEMADR: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_IMM;
                    ctrl.alu_operation = ALUOP_ADD;
                end
                S_MEMRD: begin
                    ctrl.mem_req = 1'b1;
                    ctrl.ior_d   = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = 1'b0;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.mem_req   = 1'b1;
                    ctrl.mem_write = 1'b1;
                    ctrl.ior_d     = 1'b1;
                end
                S_EXECUTE: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_REGB;
                    ctrl.alu_operation = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = 1'b1;
                    ctrl.mem_to_reg = 1'b0;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_REGB;
                    ctrl.alu_operation = ALUOP_SUB;
                    ctrl.branch        = 1'b1;
                    ctrl.pc_src        = PCSRC_ALUOUT;
                end
                S_ADDIEX: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_IMM;
                    ctrl.alu_operation = ALUOP_ADD;
                end
                S_ADDIWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = 1'b0;
                    ctrl.mem_to_reg = 1'b0;
                end
                S_JUMP: begin
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PCSRC_JUMP;
                end
                default: begin
                    ctrl = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mips_main_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback, tracks memory wait time and raises a sticky timeout flag.
module mips_main_controller
    import mips_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       ior_d,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_operation,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic       mem_timeout
);

    // A limit of zero disables the timeout; the 4-bit counter saturates at
    // 15, so larger limits can never be reached either.
    localparam logic       TIMEOUT_EN = (MEM_WAIT_MAX > 0) && (MEM_WAIT_MAX <= 15);
    localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT_MAX);

    ctrl_state_t   state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic          mem_timeout_q, mem_timeout_d;
    ctrl_outputs_t ctrl;

    // State, wait counter and timeout flag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            wait_cnt_q    <= 4'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Next-state sequencing; memory states hold until mem_ready.
    // MEMADR looks at the opcode again to split loads from stores, which is
    // safe because the IR is not reloaded until the next FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Count stalled memory cycles within one state visit; the timeout flag
    // latches the first time the count lands on the limit and the access
    // keeps waiting regardless.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = 4'd0;
        end else if (is_wait_state(state_q) && !mem_ready && (wait_cnt_q != 4'hF)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
        mem_timeout_d = mem_timeout_q |
                        (TIMEOUT_EN && (wait_cnt_d == WAIT_LIMIT));
    end

    // Output decode lives in its own block so the control table reads in
    // one place
    mips_ctrl_output_decode u_output_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .reset     (reset),
        .opcode    (opcode),
        .ctrl      (ctrl)
    );

    assign ior_d         = ctrl.ior_d;
    assign mem_req       = ctrl.mem_req;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign branch        = ctrl.branch;
    assign pc_src        = ctrl.pc_src;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_operation = ctrl.alu_operation;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign illegal_op    = ctrl.illegal_op;
    assign mem_timeout   = mem_timeout_q;

endmodule

// File: tb/tb_mips_main_controller.sv
// Self-checking bench for the multicycle MIPS main controller. A reference
// model keeps a queue of the steps each instruction still has to perform
// and predicts every control output cycle by cycle.
module tb_mips_main_controller;

    localparam int WAIT_MAX = 2;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_BAD   = 6'b111111;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
        P_EXEC, P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP
    } phase_e;

    typedef struct packed {
        logic       ior_d;
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_operation;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
        logic       mem_timeout;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       ior_d, mem_req, mem_write, ir_write, pc_write, branch;
    logic [1:0] pc_src, alu_src_b, alu_operation;
    logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal_op, mem_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: remaining steps, stalled cycles, sticky flag
    phase_e plan[$];
    int     m_waits = 0;
    logic   m_tmo   = 1'b0;

    outs_t  act_now, exp_vec, act_vec;
    outs_t  exp_q[$];
    outs_t  act_q[$];
    phase_e ph_q[$];
    phase_e last_ph;

    mips_main_controller #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .ior_d         (ior_d),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .branch        (branch),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_operation (alu_operation),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .illegal_op    (illegal_op),
        .mem_timeout   (mem_timeout)
    );

    always #5 clk = ~clk;

    assign act_now = {ior_d, mem_req, mem_write, ir_write, pc_write, branch, pc_src,
                      alu_src_a, alu_src_b, alu_operation, reg_write, reg_dst,
                      mem_to_reg, illegal_op, mem_timeout};

    function automatic phase_e cur_phase();
        if (plan.size() == 0) return P_FETCH;
        return plan[0];
    endfunction

    // Expected controls for one cycle, straight from the instruction table
    function automatic outs_t model_outs(phase_e ph, logic rdy, logic [5:0] op,
                                         logic rst, logic tmo);
        outs_t o = '0;
        o.mem_timeout = tmo;
        if (rst) return o;
        case (ph)
            P_FETCH:  begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            P_DECODE: begin
                o.alu_src_b  = 2'b11;
                o.illegal_op = !(op inside {T_RTYPE, T_LW, T_SW, T_BEQ, T_ADDI, T_J});
            end
            P_MEMADR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            P_MEMRD:  begin o.mem_req = 1; o.ior_d = 1; end
            P_MEMWB:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            P_MEMWR:  begin o.mem_req = 1; o.mem_write = 1; o.ior_d = 1; end
            P_EXEC:   begin o.alu_src_a = 1; o.alu_operation = 2'b10; end
            P_ALUWB:  begin o.reg_write = 1; o.reg_dst = 1; end
            P_BRANCH: begin o.alu_src_a = 1; o.alu_operation = 2'b01; o.branch = 1; o.pc_src = 2'b01; end
            P_ADDIEX: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            P_ADDIWB: begin o.reg_write = 1; end
            P_JUMP:   begin o.pc_write = 1; o.pc_src = 2'b10; end
            default:  o = '0;
        endcase
        return o;
    endfunction

    // Advance the model across one clock edge
    task automatic model_advance(input logic rst, input logic [5:0] op, input logic rdy);
        phase_e ph;
        logic   stalled;
        ph      = cur_phase();
        stalled = 1'b0;
        if (rst) begin
            plan.delete();
            m_waits = 0;
            m_tmo   = 1'b0;
            return;
        end
        case (ph)
            P_FETCH: if (rdy) plan.push_back(P_DECODE); else stalled = 1'b1;
            P_DECODE: begin
                void'(plan.pop_front());
                case (op)
                    T_LW:    begin plan.push_back(P_MEMADR); plan.push_back(P_MEMRD); plan.push_back(P_MEMWB); end
                    T_SW:    begin plan.push_back(P_MEMADR); plan.push_back(P_MEMWR); end
                    T_RTYPE: begin plan.push_back(P_EXEC);   plan.push_back(P_ALUWB); end
                    T_ADDI:  begin plan.push_back(P_ADDIEX); plan.push_back(P_ADDIWB); end
                    T_BEQ:   plan.push_back(P_BRANCH);
                    T_J:     plan.push_back(P_JUMP);
                    default: ;
                endcase
            end
            P_MEMRD, P_MEMWR: if (rdy) void'(plan.pop_front()); else stalled = 1'b1;
            default: void'(plan.pop_front());
        endcase
        if (stalled) begin
            m_waits++;
            if (m_waits >= WAIT_MAX) m_tmo = 1'b1;
        end else begin
            m_waits = 0;
        end
    endtask

    // Drive one cycle: inputs after the falling edge, sample 1 ns later,
    // then let the rising edge happen
    task automatic step(input logic rst, input logic [5:0] op, input logic rdy);
        reset     = rst;
        opcode    = op;
        mem_ready = rdy;
        #1;
        last_ph = cur_phase();
        exp_vec = model_outs(last_ph, rdy, op, rst, m_tmo);
        act_vec = act_now;
        model_advance(rst, op, rdy);
        @(negedge clk);
    endtask

    // Run one instruction from FETCH back to FETCH, recording every cycle
    task automatic run_instr(input logic [5:0] op, input int wait_fetch, input int wait_mem);
        int     waited;
        int     guard;
        phase_e prev;
        logic   rdy;
        exp_q.delete(); act_q.delete(); ph_q.delete();
        for (int i = 0; i <= wait_fetch; i++) begin
            step(1'b0, op, (i == wait_fetch));
            exp_q.push_back(exp_vec); act_q.push_back(act_vec); ph_q.push_back(last_ph);
        end
        waited = 0;
        guard  = 0;
        prev   = P_FETCH;
        while (cur_phase() != P_FETCH && guard < 40) begin
            if (cur_phase() != prev) waited = 0;
            prev = cur_phase();
            if (prev == P_MEMRD || prev == P_MEMWR) begin
                rdy = (waited < wait_mem) ? 1'b0 : 1'b1;
                waited++;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            step(1'b0, op, rdy);
            exp_q.push_back(exp_vec); act_q.push_back(act_vec); ph_q.push_back(last_ph);
            guard++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 6'($urandom), 1'($urandom));
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL reset_hold cyc%0d: got %h want %h", i, act_vec, exp_vec);
            end
        end
        step(1'b0, T_LW, 1'b0);
        n_cmp++;
        if ({act_vec.mem_req, act_vec.ior_d, act_vec.alu_src_b, act_vec.mem_timeout} !== 5'b10010) begin
            n_fail++;
            $display("[TB] FAIL reset_exit_fetch: got %h want FETCH signature", act_vec);
        end
        // the stall above leaves the model mid-FETCH; complete it cleanly
        step(1'b1, T_LW, 1'b0);
    endtask

    // Directed instruction with per-cycle comparison and a return-to-FETCH check
    task automatic test_instr(input string name, input logic [5:0] op, input int cycles_exp);
        run_instr(op, 0, 0);
        for (int i = 0; i < act_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL %s cyc%0d %s: got %h want %h", name, i, ph_q[i].name(), act_q[i], exp_q[i]);
            end
        end
        step(1'b0, op, 1'b1);
        n_cmp++;
        if ({act_vec.mem_req, act_vec.ior_d, act_vec.alu_src_b, act_vec.ir_write} !== 5'b10011 ||
            act_q.size() != cycles_exp) begin
            n_fail++;
            $display("[TB] FAIL %s_length: got %h after %0d cycles want FETCH after %0d",
                     name, act_vec, act_q.size(), cycles_exp);
        end
        // that FETCH completed, so finish the instruction it fetched
        while (cur_phase() != P_FETCH) step(1'b0, op, 1'b1);
    endtask

    task automatic test_sw_timeout();
        int nwr;
        step(1'b1, T_SW, 1'b0);
        run_instr(T_SW, 0, 3);
        nwr = 0;
        for (int i = 0; i < act_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL sw_wait cyc%0d %s: got %h want %h", i, ph_q[i].name(), act_q[i], exp_q[i]);
            end
            if (act_q[i].mem_write === 1'b1) nwr++;
        end
        n_cmp++;
        if (nwr != 4 || act_q.size() != 7) begin
            n_fail++;
            $display("[TB] FAIL sw_write_len: got %0d write cycles in %0d want 4 in 7", nwr, act_q.size());
        end
        n_cmp++;
        if (act_q.size() < 6 || act_q[4].mem_timeout !== 1'b0 || act_q[5].mem_timeout !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL timeout_set_cycle: got wait2/wait3 flags wrong, want 0 then 1");
        end
        run_instr(T_RTYPE, 0, 0);
        run_instr(T_J, 0, 0);
        n_cmp++;
        if (act_q[act_q.size()-1].mem_timeout !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL timeout_sticky: got %b want 1", act_q[act_q.size()-1].mem_timeout);
        end
        step(1'b1, T_J, 1'b0);
        step(1'b0, T_J, 1'b0);
        n_cmp++;
        if (act_vec.mem_timeout !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL timeout_clear: got %b want 0", act_vec.mem_timeout);
        end
        step(1'b1, T_J, 1'b0);
    endtask

    task automatic test_illegal();
        int npulse;
        run_instr(T_BAD, 0, 0);
        npulse = 0;
        for (int i = 0; i < act_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL illegal cyc%0d: got %h want %h", i, act_q[i], exp_q[i]);
            end
            if (act_q[i].illegal_op === 1'b1) npulse++;
        end
        n_cmp++;
        if (npulse != 1 || act_q.size() != 2 ||
            {act_q[1].reg_write, act_q[1].mem_write, act_q[1].pc_write} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL illegal_pulse: got %0d pulses over %0d cycles want 1 over 2", npulse, act_q.size());
        end
    endtask

    task automatic test_reset_mid_memrd();
        step(1'b0, T_LW, 1'b1);
        step(1'b0, T_LW, 1'b1);
        step(1'b0, T_LW, 1'b1);
        step(1'b0, T_LW, 1'b0);
        step(1'b0, T_LW, 1'b0);
        step(1'b1, T_LW, 1'b0);
        n_cmp++;
        if ({act_vec.mem_req, act_vec.mem_write, act_vec.ir_write, act_vec.pc_write,
             act_vec.branch, act_vec.reg_write, act_vec.illegal_op} !== 7'b0 ||
            act_vec !== exp_vec) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_enables: got %h want %h", act_vec, exp_vec);
        end
        step(1'b0, T_LW, 1'b0);
        n_cmp++;
        if ({act_vec.mem_req, act_vec.ior_d, act_vec.alu_src_b, act_vec.mem_timeout} !== 5'b10010) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_exit: got %h want FETCH with timeout 0", act_vec);
        end
        step(1'b1, T_LW, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] seq [6];
        seq = '{T_LW, T_SW, T_RTYPE, T_BEQ, T_ADDI, T_J};
        for (int k = 0; k < 6; k++) begin
            run_instr(seq[k], k % 2, 0);
            for (int i = 0; i < act_q.size(); i++) begin
                n_cmp++;
                if (act_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("[TB] FAIL b2b op%0d cyc%0d %s: got %h want %h", k, i, ph_q[i].name(), act_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] pool [7];
        logic [5:0] cur_op;
        logic       rst, rdy;
        pool   = '{T_RTYPE, T_LW, T_SW, T_BEQ, T_ADDI, T_J, T_BAD};
        cur_op = T_LW;
        for (int i = 0; i < 400; i++) begin
            if (cur_phase() == P_FETCH) cur_op = pool[$urandom_range(0, 6)];
            rst = ($urandom_range(0, 49) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(rst, cur_op, rdy);
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL random cyc%0d %s op=%b: got %h want %h", i, last_ph.name(), cur_op, act_vec, exp_vec);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_instr("lw",    T_LW,    5);
        test_instr("rtype", T_RTYPE, 4);
        test_instr("addi",  T_ADDI,  4);
        test_instr("sw",    T_SW,    4);
        test_instr("beq",   T_BEQ,   3);
        test_instr("j",     T_J,     3);
        test_sw_timeout();
        test_illegal();
        test_reset_mid_memrd();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mips_main_controller.md
Name: mips_main_controller

Overview:
- Multicycle MIPS control FSM. It sequences fetch, decode, execute, memory and writeback for every instruction.
- Drives all datapath enables and multiplexer selects.
- Produces the 2-bit alu_operation class code that the ALU function decoder consumes alongside funct.
- Sits between the instruction register opcode field and the multicycle datapath, with a ready handshake to the unified instruction/data memory.

Parameters:
- MEM_WAIT_MAX, 15, cycles a memory state waits for mem_ready before flagging mem_timeout. 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  instr[31:26] from the instruction register.
- mem_ready  input  1  memory completes the current access this cycle.
- ior_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_req  output  1  memory access request.
- mem_write  output  1  write qualifier for mem_req.
- ir_write  output  1  instruction register load.
- pc_write  output  1  unconditional PC load.
- branch  output  1  conditional PC load; the datapath ANDs it with zero.
- pc_src  output  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_operation  output  2  ALU class: 00 = add, 01 = subtract, 10 = use funct. 11 is never driven.
- reg_write  output  1  register file write.
- reg_dst  output  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg  output  1  writeback source: 0 = ALUOut, 1 = MDR.
- illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded.
- mem_timeout  output  1  sticky flag; cleared only by reset.

Behaviour:
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Reset:
  - While reset = 1, every enable output is 0: mem_req, mem_write, ir_write, pc_write, branch, reg_write, illegal_op.
  - While reset = 1, every select output is 0 and alu_operation is 00.
  - The cycle after reset deasserts, the state is FETCH, the wait counter is 0 and mem_timeout is 0.
  - Reset asserted mid-instruction aborts it; no write enable fires in the reset cycle.
- Outputs are decoded from the state (Moore), except ir_write and pc_write in FETCH, which also require mem_ready.
- FETCH:
  - Drives mem_req = 1, ior_d = 0, alu_src_a = 0, alu_src_b = 01, alu_operation = 00, pc_src = 00.
  - Holds until mem_ready = 1. In that cycle it drives ir_write = 1 and pc_write = 1, then goes to DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_operation = 00 (branch target precompute). Next state by opcode:
  - LW or SW -> MEMADR
  - RTYPE -> EXECUTE
  - BEQ -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - anything else -> FETCH, with illegal_op = 1 in this DECODE cycle.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_operation = 00. Next state is MEMRD for LW, MEMWR for SW. The opcode is re-sampled here; the IR is stable.
- MEMRD: mem_req = 1, ior_d = 1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1, then FETCH.
- MEMWR: mem_req = 1, mem_write = 1, ior_d = 1. Holds until mem_ready, then FETCH.
- EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_operation = 10, then ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0, then FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_operation = 01, branch = 1, pc_src = 01, then FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_operation = 00, then ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0, then FETCH.
- JUMP: pc_write = 1, pc_src = 10, then FETCH.
- Cycle counts with mem_ready tied high:
  - LW = 5 cycles
  - SW, RTYPE, ADDI = 4 cycles
  - BEQ, J = 3 cycles
- Wait counter (4 bits):
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready = 0; saturates at 15.
  - Clears on any state change.
  - When it reaches MEM_WAIT_MAX, mem_timeout sets. The FSM keeps waiting; the timeout does not abort the access.
- mem_ready outside the memory states is ignored.
- mem_ready that is high on the first cycle of a memory state completes that access in that cycle.

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - the alu_operation encodings: ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10
  - the pc_src and alu_src_b select encodings
  - the controller state enum ctrl_state_t.
- The ALU function decoder imports the same ALUOP constants.
- One sub-module is natural: mips_ctrl_output_decode, a combinational map from state, mem_ready and reset to all outputs. The state register, next-state logic and wait counter stay in the top module.

Test Plan:
- Reset, then LW (opcode 100011) with mem_ready always 1:
  - States FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH across 5 cycles.
  - reg_write = 1 and mem_to_reg = 1 only in cycle 5; alu_operation is 00 in every cycle.
- RTYPE (000000):
  - alu_operation = 10 only in EXECUTE.
  - In ALUWB, reg_write = 1 and reg_dst = 1.
  - Back in FETCH after 4 cycles.
- BEQ (000100):
  - In BRANCH, alu_operation = 01, branch = 1, pc_src = 01, pc_write = 0.
  - J (000010): in JUMP, pc_write = 1 and pc_src = 10; 3 cycles each.
- SW with mem_ready low for 3 cycles in MEMWR:
  - mem_write = 1 held for 4 cycles, then FETCH.
  - With MEM_WAIT_MAX = 2, mem_timeout sets on the 3rd wait cycle and stays 1 until reset.
- Opcode 111111 in DECODE: illegal_op pulses for exactly 1 cycle, the next state is FETCH, and reg_write, mem_write and pc_write all stay 0.
- Reset asserted during MEMRD with mem_ready = 0: all enables are 0 that cycle, the state is FETCH the cycle after reset deasserts, and mem_timeout is 0.
